// File: rtl/adc_ramp_trig_gen.sv
// Four signed sawtooth ADC sample streams plus a periodic, run/pause-able trigger pulse.
module adc_ramp_trig_gen #(
    parameter int unsigned DW           = 14,
    parameter int unsigned CW           = 16,
    parameter int          LO           = -1000,
    parameter int          HI           = 1000,
    parameter int          START0       = -1000,
    parameter int          START1       = -500,
    parameter int          START2       = 1000,
    parameter int          START3       = 500,
    parameter int unsigned TRIG_PER     = 25000,
    parameter int unsigned TRIG_LEN     = 1,
    parameter logic        TRIG_ACT_LVL = 1'b0
) (
    input  logic                 clk0,
    input  logic                 rstn,
    input  logic                 en_i,
    input  logic [DW-1:0]        step_i,
    input  logic                 sw_trig_i,
    output logic signed [DW-1:0] ch0_o,
    output logic signed [DW-1:0] ch1_o,
    output logic signed [DW-1:0] ch2_o,
    output logic signed [DW-1:0] ch3_o,
    output logic [3:0]           wrap_o,
    output logic                 trig_o,
    output logic [CW-1:0]        trig_cnt_o,
    output logic                 busy_o
);

    localparam int unsigned       XW     = DW + 2;
    localparam logic signed [XW-1:0] HI_X = XW'(HI);
    localparam logic signed [DW-1:0] HI_D = DW'(HI);
    localparam logic signed [DW-1:0] LO_D = DW'(LO);
    localparam logic [CW-1:0]     PER_C  = CW'(TRIG_PER);
    localparam logic [CW-1:0]     LEN_M1 = CW'(TRIG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PULSE = 2'd2
    } state_t;

    logic signed [DW-1:0] ch_q   [4];
    logic signed [DW-1:0] ch_nxt [4];
    logic [3:0]           wrap_nxt;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic          trig_d, busy_d;

    // Per-channel next sample: wrap to LO once at HI, else add step clamped to HI.
    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic signed [XW-1:0] cur_x;
        logic signed [XW-1:0] sum_x;
        assign cur_x       = {{2{ch_q[k][DW-1]}}, ch_q[k]};
        assign sum_x       = cur_x + $signed({2'b00, step_i});
        assign wrap_nxt[k] = (cur_x >= HI_X);
        assign ch_nxt[k]   = (cur_x >= HI_X) ? LO_D :
                             (sum_x >= HI_X) ? HI_D : sum_x[DW-1:0];
    end

    // Ramp registers: advance only while enabled; wrap strobe lasts one cycle.
    always_ff @(posedge clk0) begin
        if (!rstn) begin
            ch_q[0] <= DW'(START0);
            ch_q[1] <= DW'(START1);
            ch_q[2] <= DW'(START2);
            ch_q[3] <= DW'(START3);
            wrap_o  <= '0;
        end else if (en_i) begin
            for (int k = 0; k < 4; k++) begin
                ch_q[k] <= ch_nxt[k];
            end
            wrap_o <= wrap_nxt;
        end else begin
            wrap_o <= '0;
        end
    end

    assign ch0_o = ch_q[0];
    assign ch1_o = ch_q[1];
    assign ch2_o = ch_q[2];
    assign ch3_o = ch_q[3];

    // Trigger FSM state, counters and registered outputs.
    always_ff @(posedge clk0) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            trig_o     <= ~TRIG_ACT_LVL;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            trig_o     <= trig_d;
            busy_o     <= busy_d;
        end
    end

    assign trig_cnt_o = cnt_q;

    // Next-state logic; outputs follow the state being entered so the pulse starts on the deciding edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        trig_d  = ~TRIG_ACT_LVL;
        busy_d  = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
                RUN: begin
                    if ((cnt_q == PER_C) || sw_trig_i) begin
                        state_d = PULSE;
                        cnt_d   = '0;
                        pcnt_d  = LEN_M1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PULSE: begin
                    cnt_d = cnt_q + CW'(1);
                    if (pcnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        pcnt_d = pcnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end
            endcase
        end
        if (state_d == PULSE) begin
            trig_d = TRIG_ACT_LVL;
            busy_d = 1'b1;
        end
    end

endmodule
